// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Ports: clk, reset (async, active-low), MemWrite/Addr/WriteData from the core,
//   ReadData/Sel back to the core read mux, tx serial line, busy.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Sel,
    output logic        tx,
    output logic        busy
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]    r_state;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_overrun;
    logic [15:0]   r_div;
    logic [15:0]   r_timer;
    logic [7:0]    r_shift;
    logic [2:0]    r_bitcnt;

    logic [1:0]    w_off;
    logic          w_empty;
    logic          w_full;
    logic          w_push_req;
    logic          w_accept;
    logic          w_pop;
    logic          w_bit_end;
    logic [15:0]   w_reload;
    logic [7:0]    w_head;
    logic          w_ovr_clr;
    logic          w_div_wr;
    logic [31:0]   w_status;
    logic          w_unused_bits;

    assign w_unused_bits = ^{Addr[1:0], WriteData[31:16]};

    assign w_off     = Addr[3:2];
    assign Sel       = (Addr[31:4] == BASE_ADDR[31:4]);
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == DEPTH_C);
    assign w_bit_end = (r_timer == 16'd0);
    // Divisor 0 behaves as 1, i.e. a zero-length countdown.
    assign w_reload  = (r_div == 16'd0) ? 16'd0 : r_div - 16'd1;
    assign w_head    = r_mem[r_rd_ptr];

    assign w_push_req = MemWrite & Sel & (w_off == 2'd0);
    assign w_ovr_clr  = MemWrite & Sel & (w_off == 2'd1) & WriteData[3];
    assign w_div_wr   = MemWrite & Sel & (w_off == 2'd2);

    // Head leaves the FIFO when idle, or exactly when a stop bit ends.
    assign w_pop = ~w_empty &
                   ((r_state == S_IDLE) |
                    ((r_state == S_STOP) & w_bit_end));

    // A full FIFO still takes a byte if the head leaves on the same edge.
    assign w_accept = w_push_req & (~w_full | w_pop);

    assign busy = (r_state != S_IDLE);

    always_comb begin
        tx = 1'b1;
        if (r_state == S_START) begin
            tx = 1'b0;
        end else if (r_state == S_DATA) begin
            tx = r_shift[0];
        end
    end

    assign w_status = {23'd0, 5'(r_count), r_overrun, busy, w_empty, w_full};

    always_comb begin
        ReadData = 32'd0;
        if (Sel) begin
            unique case (w_off)
                2'd1:    ReadData = w_status;
                2'd2:    ReadData = {16'd0, r_div};
                default: ReadData = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= WriteData[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overrun <= 1'b0;
            r_div     <= DIV_RESET;
        end else begin
            // A dropped byte wins over a same-edge clear.
            if (w_push_req & ~w_accept) begin
                r_overrun <= 1'b1;
            end else if (w_ovr_clr) begin
                r_overrun <= 1'b0;
            end
            if (w_div_wr) begin
                r_div <= WriteData[15:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_timer  <= 16'd0;
            r_shift  <= 8'd0;
            r_bitcnt <= 3'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_shift <= w_head;
                        r_timer <= w_reload;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_timer  <= w_reload;
                        r_bitcnt <= 3'd0;
                        r_state  <= S_DATA;
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_timer <= w_reload;
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bitcnt == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bitcnt <= r_bitcnt + 3'd1;
                        end
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        if (!w_empty) begin
                            r_shift <= w_head;
                            r_timer <= w_reload;
                            r_state <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Testbench for mmio_uart_tx: directed register accesses with a frame scoreboard.
// A monitor decodes every frame on tx and checks it against the queued expectation.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] Addr = 32'd0;
    logic [31:0] WriteData = 32'd0;
    logic [31:0] ReadData;
    logic        Sel;
    logic        tx;
    logic        busy;

    mmio_uart_tx dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Sel       (Sel),
        .tx        (tx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0]      data;
        logic [9:0][7:0] dur;
        logic            chk_start;
        logic [31:0]     start;
        logic            nogap;
    } frame_t;

    frame_t exp_q[$];
    bit     mon_en = 1'b0;
    bit     mon_active = 1'b0;
    int     last_end = -100;
    int     fno = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        Addr = a;
        WriteData = d;
        MemWrite = 1'b1;
        @(negedge clk);
        MemWrite = 1'b0;
        Addr = 32'd0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e,
                      input string name);
        Addr = a;
        MemWrite = 1'b0;
        #1;
        check(name, ReadData, e);
    endtask

    task automatic push_frame(input logic [7:0] d, input int div,
                              input int start, input bit chk,
                              input bit nogap);
        frame_t f;
        f.data = d;
        for (int i = 0; i < 10; i++) f.dur[i] = 8'((div == 0) ? 1 : div);
        f.chk_start = chk;
        f.start = 32'(start);
        f.nogap = nogap;
        exp_q.push_back(f);
    endtask

    task automatic wait_idle(input int limit);
        bit done;
        done = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (exp_q.size() == 0 && !mon_active && !busy) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!done) check("wait_idle_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic count_busy(input int window, output int n);
        n = 0;
        for (int i = 0; i < window; i++) begin
            @(negedge clk);
            if (busy) n++;
        end
    endtask

    // Frame monitor
    initial begin
        frame_t f;
        logic   eb;
        logic   act;
        bit     bad;
        forever begin
            @(negedge clk);
            if (mon_en && reset && cyc == last_end + 1 && tx == 1'b1) begin
                check("stop_end_busy", 32'(busy), 32'd0);
            end
            if (mon_en && reset && tx == 1'b0) begin
                mon_active = 1'b1;
                if (exp_q.size() == 0) begin
                    check("unexpected_frame_tx", 32'(tx), 32'd1);
                    for (int k = 0; k < 400 && busy; k++) @(negedge clk);
                end else begin
                    f = exp_q.pop_front();
                    fno++;
                    if (f.chk_start) begin
                        check($sformatf("frame%0d_start_cycle", fno),
                              32'(cyc), f.start);
                    end
                    if (f.nogap) begin
                        check($sformatf("frame%0d_gap", fno),
                              32'(cyc), 32'(last_end + 1));
                    end
                    for (int b = 0; b < 10; b++) begin
                        if (b == 0)      eb = 1'b0;
                        else if (b == 9) eb = 1'b1;
                        else             eb = f.data[b-1];
                        bad = 1'b0;
                        act = eb;
                        for (int k = 0; k < int'(f.dur[b]); k++) begin
                            if (!(b == 0 && k == 0)) @(negedge clk);
                            if (tx !== eb && !bad) begin
                                bad = 1'b1;
                                act = tx;
                            end
                        end
                        check($sformatf("frame%0d_bit%0d", fno, b),
                              32'(act), 32'(eb));
                    end
                    last_end = cyc;
                end
                mon_active = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        frame_t fc;
        int n;
        int n1;
        logic [7:0] b[6];

        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        rd(BASE + 32'h4, 32'h002, "reset_status");
        rd(BASE + 32'h8, 32'd434, "reset_div");
        check("sel_base", 32'(Sel), 32'd1);

        // Abandon a frame with an asynchronous reset
        wr(BASE + 32'h8, 32'd4);
        wr(BASE, 32'h55);
        repeat (12) @(negedge clk);
        check("midframe_busy", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_reset_tx", 32'(tx), 32'd1);
        check("async_reset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        rd(BASE + 32'h4, 32'h002, "after_reset_status");
        rd(BASE + 32'h8, 32'd434, "after_reset_div");
        mon_en = 1'b1;

        // Single byte, DIV=4
        wr(BASE + 32'h8, 32'd4);
        push_frame(8'hA5, 4, cyc + 2, 1'b1, 1'b0);
        wr(BASE, 32'hA5);
        count_busy(60, n);
        check("busy_cycles_div4", 32'(n), 32'd40);
        wait_idle(3000);

        // Burst of 6 with overrun, DIV=2
        wr(BASE + 32'h8, 32'd2);
        b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        push_frame(b[0], 2, cyc + 2, 1'b1, 1'b0);
        for (int i = 1; i < 5; i++) push_frame(b[i], 2, 0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) wr(BASE, {24'd0, b[i]});
        rd(BASE + 32'h4, 32'h04D, "burst_status");
        wait_idle(3000);
        rd(BASE + 32'h4, 32'h00A, "burst_overrun_status");
        wr(BASE + 32'h4, 32'h8);
        rd(BASE + 32'h4, 32'h002, "overrun_cleared");

        // Push into a full FIFO on the edge the stop bit ends
        b = '{8'hC3, 8'h0F, 8'hF0, 8'h81, 8'h7E, 8'h99};
        push_frame(b[0], 2, cyc + 2, 1'b1, 1'b0);
        for (int i = 1; i < 6; i++) push_frame(b[i], 2, 0, 1'b0, 1'b1);
        wr(BASE, {24'd0, b[0]});
        n1 = cyc;
        for (int i = 1; i < 5; i++) wr(BASE, {24'd0, b[i]});
        while (cyc < n1 + 20) @(negedge clk);
        wr(BASE, {24'd0, b[5]});
        rd(BASE + 32'h4, 32'h045, "full_push_pop_status");
        wait_idle(3000);
        rd(BASE + 32'h4, 32'h002, "full_push_no_overrun");

        // DIV=0 behaves as 1
        wr(BASE + 32'h8, 32'd0);
        rd(BASE + 32'h8, 32'd0, "div_zero_readback");
        push_frame(8'h96, 0, cyc + 2, 1'b1, 1'b0);
        wr(BASE, 32'h96);
        count_busy(30, n);
        check("busy_cycles_div0", 32'(n), 32'd10);
        wait_idle(3000);

        // DIV 8 -> 2 during data bit 3
        wr(BASE + 32'h8, 32'd8);
        fc.data = 8'h5A;
        for (int i = 0; i < 10; i++) fc.dur[i] = (i < 5) ? 8'd8 : 8'd2;
        fc.chk_start = 1'b1;
        fc.start = 32'(cyc + 2);
        fc.nogap = 1'b0;
        exp_q.push_back(fc);
        wr(BASE, 32'h5A);
        n1 = cyc;
        while (cyc < n1 + 34) @(negedge clk);
        wr(BASE + 32'h8, 32'd2);
        wait_idle(3000);
        rd(BASE + 32'h8, 32'd2, "div_after_change");

        // Address decode
        rd(BASE, 32'd0, "txdata_reads_zero");
        Addr = BASE + 32'hC;
        #1 check("sel_reserved", 32'(Sel), 32'd1);
        rd(BASE + 32'hC, 32'd0, "reserved_reads_zero");
        wr(BASE + 32'hC, 32'hFFFF_FFFF);
        rd(BASE + 32'h9, 32'd2, "div_byte_offset_ignored");
        rd(BASE + 32'h4, 32'h002, "status_after_reserved_wr");
        Addr = BASE + 32'h10;
        #1 check("sel_outside", 32'(Sel), 32'd0);
        rd(BASE + 32'h10, 32'd0, "outside_reads_zero");
        wr(BASE + 32'h10, 32'hA5);
        wr(BASE + 32'h18, 32'd4);
        repeat (20) @(negedge clk);
        rd(BASE + 32'h4, 32'h002, "status_after_outside_wr");
        rd(BASE + 32'h8, 32'd2, "div_after_outside_wr");

        wait_idle(3000);
        repeat (10) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the single-cycle core's data-memory port. It decodes the core's store/load address (ALUResult), accepts byte writes into a small TX FIFO, and serialises them 8N1 on `tx`. It also returns status and divisor reads combinationally so the core's same-cycle ReadData path is satisfied. The top-level data mux selects this block's `ReadData` when `Sel` is high, and RAM otherwise.

## Interface
- `BASE_ADDR`, default 32'hFFFF_FF00: word-aligned base of the 16-byte register window.
- `FIFO_DEPTH`, default 4: TX FIFO entries; power of two, 2..16.
- `DIV_RESET`, default 16'd434: bit-period divisor after reset (50 MHz / 115200).
- `clk` in 1: core clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `MemWrite` in 1: core store strobe.
- `Addr` in 32: core ALUResult (byte address).
- `WriteData` in 32: core store data.
- `ReadData` out 32: combinational read data; 0 when `Sel`=0.
- `Sel` out 1: combinational; 1 when Addr[31:4] == BASE_ADDR[31:4].
- `tx` out 1: serial line, idles high.
- `busy` out 1: 1 while the FSM is not IDLE.

## Operation
- Register map (offset = Addr[3:2]; Addr[1:0] ignored):
  - 0 TXDATA, write-only: push WriteData[7:0]. Reads return 0.
  - 1 STATUS: bit0 full, bit1 empty, bit2 busy, bit3 overrun (sticky), bits[8:4] count. Other bits 0. Writing with WriteData[3]=1 clears overrun; other bits are ignored.
  - 2 DIVISOR: bits[15:0] R/W. A value of 0 is treated as 1.
  - 3: reserved; reads 0, writes ignored.
- Push occurs when MemWrite & Sel & offset==0 at a rising edge.
- A push is accepted if count<FIFO_DEPTH, or if a pop occurs on the same edge.
- Otherwise the byte is dropped and overrun is set. If an overrun clear and a dropping push hit the same edge, overrun stays set.
- FIFO: circular, with rd/wr pointers wrapping modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty: pop the head into the shift register, load the bit timer, and go to START.
  - START: tx=0 for one bit period, then DATA.
  - DATA: tx=shift[0], LSB first. After each bit period, shift right. After 8 bits, go to STOP.
  - STOP: tx=1 for one bit period. At the end, if the FIFO is non-empty, pop and go directly to START (no extra idle cycles); else go to IDLE.
- Bit timer: loads max(DIVISOR,1)-1 at each bit start and decrements to 0. A bit ends on the cycle the timer reads 0.
- A DIVISOR write mid-frame takes effect at the next bit boundary.
- Reset (asynchronous, any time, including mid-frame):
  - State IDLE; FIFO empty (count 0).
  - overrun=0; DIVISOR=DIV_RESET.
  - tx=1, busy=0.
  - A partially sent frame is abandoned.

## Timing
- Write-to-line latency: a TXDATA write at edge N while IDLE sets empty=0 at N. The FSM pops at edge N+1, and tx falls after N+1.
- Frame length: 10·max(DIV,1) cycles from tx falling to the end of the stop bit.
- Back-to-back bytes produce no idle gap between the stop bit and the next start bit.
- ReadData and Sel are purely combinational from Addr and registered state. STATUS reflects state before the current edge's update.
- A pop and a push on the same edge keep count unchanged.

## Test plan
- Reset then idle: drive reset=0 mid-frame, release → tx=1, busy=0, STATUS reads 0x002, DIVISOR reads 434.
- Single byte: DIV=4, write 0xA5 to TXDATA → tx falls 1 cycle later. Sequence 0, then 1,0,1,0,0,1,0,1 (LSB first), then 1; each level held 4 cycles; busy is high for exactly 40 cycles.
- Burst and overrun: DIV=2, write 6 bytes on consecutive cycles with FIFO_DEPTH=4.
  - 1st is popped immediately; the next 4 fill the FIFO; the 6th is dropped.
  - Overrun=1; exactly 5 frames sent back-to-back with no gap.
  - Write STATUS 0x8 → overrun=0.
- Full push with simultaneous pop: FIFO full, push at the exact edge STOP ends → byte accepted, count stays 4, no overrun.
- Divisor edge cases: DIV=0 → 1 cycle/bit, 10-cycle frame. Change DIV 8→2 during the DATA bit 3 period → bit 3 lasts 8 cycles, bit 4 onward 2 cycles.
- Decode: read/write BASE+0xC and BASE+0x10 → ReadData=0, no state change. For Sel=0 at BASE+0x10, ReadData=0.
